sprite_scheduler: RTL and testbench

- Central controller for up to NUM_SPRITES widget instances on the 800x600 VGA path.
- Arbitrates pixel ownership between overlapping sprites by fixed priority and drives the registered colour to the DAC.
- Paces sprite motion with a per-frame move strobe and supports run/pause/single-step.
- Detects sprite-to-sprite collisions and reports them once per frame.

---
 rtl/vga_pkg.sv | 15 +
 rtl/sprite_prio_mux.sv | 28 ++
 rtl/sprite_scheduler.sv | 136 +++++++++++++
 tb/tb_sprite_scheduler.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the 800x600 sprite path: screen limits, scheduler
// state encodings and the packed RGB slice width.
package vga_pkg;

   localparam int VGA_H_LAST = 799;
   localparam int VGA_V_LAST = 599;
   localparam int RGB_W      = 12;

   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,
      ST_PAUSE = 2'b01,
      ST_STEP  = 2'b10
   } run_state_e;

endpackage

// File: rtl/sprite_prio_mux.sv
// Fixed-priority pixel owner select: lowest-index hit wins, otherwise the
// background colour with owner = NUM_SPRITES.
module sprite_prio_mux
   import vga_pkg::*;
#(
   parameter int NUM_SPRITES = 4,
   parameter int OWN_W       = 3
) (
   input  logic [NUM_SPRITES-1:0]       hit,
   input  logic [RGB_W*NUM_SPRITES-1:0] sprite_rgb,
   input  logic [RGB_W-1:0]             bg_rgb,
   output logic [OWN_W-1:0]             owner,
   output logic [RGB_W-1:0]             rgb
);

   // Scan from the top down so the lowest asserted index is written last.
   always_comb begin
      owner = OWN_W'(NUM_SPRITES);
      rgb   = bg_rgb;
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
         if (hit[i]) begin
            owner = OWN_W'(i);
            rgb   = sprite_rgb[i*RGB_W +: RGB_W];
         end
      end
   end

endmodule

// File: rtl/sprite_scheduler.sv
// Sprite controller: priority colour output, frame-paced move strobe with
// run/pause/single-step control, and per-frame collision reporting.
module sprite_scheduler
   import vga_pkg::*;
#(
   parameter int NUM_SPRITES = 4,
   parameter int H_LAST      = vga_pkg::VGA_H_LAST,
   parameter int V_LAST      = vga_pkg::VGA_V_LAST,
   parameter int FRAME_DIV   = 1,
   parameter int OWN_W       = 3
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [9:0]                   X,
   input  logic [9:0]                   Y,
   input  logic [NUM_SPRITES-1:0]       hit,
   input  logic [RGB_W*NUM_SPRITES-1:0] sprite_rgb,
   input  logic [RGB_W-1:0]             bg_rgb,
   input  logic                         pause_req,
   input  logic                         step_req,
   output logic [3:0]                   red,
   output logic [3:0]                   green,
   output logic [3:0]                   blue,
   output logic [OWN_W-1:0]             owner,
   output logic                         move_tick,
   output logic [NUM_SPRITES-1:0]       collide,
   output logic                         collide_irq,
   output logic [15:0]                  frame_count,
   output logic [1:0]                   run_state
);

   localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);

   run_state_e               state, state_next;
   logic                     at_last, at_last_q, frame_end;
   logic [7:0]               div_q;
   logic                     tick_d;
   logic [NUM_SPRITES-1:0]   acc_q, coll_now, coll_new;
   logic [OWN_W-1:0]         mux_owner;
   logic [RGB_W-1:0]         mux_rgb;

   sprite_prio_mux #(
      .NUM_SPRITES (NUM_SPRITES),
      .OWN_W       (OWN_W)
   ) u_mux (
      .hit        (hit),
      .sprite_rgb (sprite_rgb),
      .bg_rgb     (bg_rgb),
      .owner      (mux_owner),
      .rgb        (mux_rgb)
   );

   // Frame end is the rising edge of the last-pixel compare, so a held
   // coordinate counts only once.
   assign at_last   = (X == 10'(H_LAST)) && (Y == 10'(V_LAST));
   assign frame_end = at_last && !at_last_q;

   // Only cycles with two or more sprites on the same pixel count as collisions.
   assign coll_now = ((hit & (hit - NUM_SPRITES'(1))) != '0) ? hit : '0;
   assign coll_new = acc_q | coll_now;

   assign run_state = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_RUN;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_RUN:   if (pause_req) state_next = ST_PAUSE;
         ST_PAUSE: begin
            if (pause_req)     state_next = ST_RUN;
            else if (step_req) state_next = ST_STEP;
         end
         ST_STEP: begin
            if (pause_req)      state_next = ST_RUN;
            else if (frame_end) state_next = ST_PAUSE;
         end
         default:  state_next = ST_RUN;
      endcase
   end

   // A pause request on the same cycle as a frame end suppresses the tick.
   always_comb begin
      tick_d = 1'b0;
      case (state)
         ST_RUN:  tick_d = frame_end && !pause_req && (div_q == DIV_LAST);
         ST_STEP: tick_d = frame_end && !pause_req;
         default: tick_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q <= '0;
      end else if (state != ST_RUN && state_next == ST_RUN) begin
         div_q <= '0;
      end else if (state == ST_RUN && frame_end && !pause_req) begin
         div_q <= (div_q == DIV_LAST) ? 8'd0 : div_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         red         <= '0;
         green       <= '0;
         blue        <= '0;
         owner       <= OWN_W'(NUM_SPRITES);
         move_tick   <= 1'b0;
         collide     <= '0;
         collide_irq <= 1'b0;
         frame_count <= '0;
         acc_q       <= '0;
         at_last_q   <= 1'b0;
      end else begin
         red         <= mux_rgb[11:8];
         green       <= mux_rgb[7:4];
         blue        <= mux_rgb[3:0];
         owner       <= mux_owner;
         move_tick   <= tick_d;
         at_last_q   <= at_last;
         collide_irq <= 1'b0;
         if (frame_end) begin
            frame_count <= frame_count + 16'd1;
            collide     <= coll_new;
            collide_irq <= (coll_new != '0);
            acc_q       <= '0;
         end else begin
            acc_q       <= coll_new;
         end
      end
   end

endmodule

// File: tb/tb_sprite_scheduler.sv
// Directed bench for sprite_scheduler: arbitration, divider pacing,
// pause/step control, collision reporting and asynchronous reset.
module tb_sprite_scheduler;

   localparam int NS = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic [9:0]     X, Y;
   logic [NS-1:0]  hit;
   logic [12*NS-1:0] sprite_rgb;
   logic [11:0]    bg_rgb;
   logic           pause_req, step_req;
   logic [3:0]     red, green, blue;
   logic [2:0]     owner;
   logic           move_tick;
   logic [NS-1:0]  collide;
   logic           collide_irq;
   logic [15:0]    frame_count;
   logic [1:0]     run_state;

   int n_checks = 0;
   int n_fail   = 0;
   int tick_cnt = 0;
   int wide_cnt = 0;
   logic prev_tick = 1'b0;

   logic          fe_tick, fe_irq, irq_after;
   logic [NS-1:0] fe_collide;
   int            t0;

   sprite_scheduler #(
      .NUM_SPRITES (NS),
      .H_LAST      (799),
      .V_LAST      (599),
      .FRAME_DIV   (2),
      .OWN_W       (3)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .X           (X),
      .Y           (Y),
      .hit         (hit),
      .sprite_rgb  (sprite_rgb),
      .bg_rgb      (bg_rgb),
      .pause_req   (pause_req),
      .step_req    (step_req),
      .red         (red),
      .green       (green),
      .blue        (blue),
      .owner       (owner),
      .move_tick   (move_tick),
      .collide     (collide),
      .collide_irq (collide_irq),
      .frame_count (frame_count),
      .run_state   (run_state)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (move_tick) begin
         tick_cnt++;
         if (prev_tick) wide_cnt++;
      end
      prev_tick = move_tick;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) cycle();
   endtask

   task automatic pulse_req(input logic p, input logic s);
      pause_req = p;
      step_req  = s;
      cycle();
      pause_req = 1'b0;
      step_req  = 1'b0;
   endtask

   // Presents the last pixel for 1+hold cycles with end_hit on the first one.
   task automatic fe(input int hold, input logic [NS-1:0] end_hit);
      X   = 10'd799;
      Y   = 10'd599;
      hit = end_hit;
      cycle();
      fe_tick    = move_tick;
      fe_irq     = collide_irq;
      fe_collide = collide;
      hit = '0;
      idle(hold);
      X = 10'd0;
      Y = 10'd0;
      cycle();
      irq_after = collide_irq;
      cycle();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      cycle();
   endtask

   initial begin
      reset      = 1'b1;
      X          = '0;
      Y          = '0;
      hit        = '0;
      pause_req  = 1'b0;
      step_req   = 1'b0;
      bg_rgb     = 12'h123;
      sprite_rgb = {12'hABC, 12'h0F0, 12'hF00, 12'h00F};
      idle(2);

      check("rst_rgb",   {red, green, blue}, 12'h000);
      check("rst_owner", owner, 3'd4);
      check("rst_tick",  move_tick, 1'b0);
      check("rst_coll",  collide, 4'h0);
      check("rst_irq",   collide_irq, 1'b0);
      check("rst_fcnt",  frame_count, 16'd0);
      check("rst_state", run_state, 2'b00);
      reset = 1'b0;
      cycle();

      hit = 4'b0110; cycle();
      check("arb_0110_rgb", {red, green, blue}, 12'hF00);
      check("arb_0110_own", owner, 3'd1);
      hit = 4'b0000; cycle();
      check("arb_bg_rgb", {red, green, blue}, 12'h123);
      check("arb_bg_own", owner, 3'd4);
      hit = 4'b1000; cycle();
      check("arb_1000_rgb", {red, green, blue}, 12'hABC);
      check("arb_1000_own", owner, 3'd3);
      hit = 4'b1111; cycle();
      check("arb_1111_rgb", {red, green, blue}, 12'h00F);
      check("arb_1111_own", owner, 3'd0);
      hit = 4'b0000; cycle();

      fe(0, '0);
      check("arb_coll",     fe_collide, 4'b1111);
      check("arb_irq",      fe_irq, 1'b1);
      check("arb_irq_done", irq_after, 1'b0);
      check("arb_fcnt",     frame_count, 16'd1);

      do_reset();
      t0 = tick_cnt;
      fe(0, '0); check("div_fe1_tick", fe_tick, 1'b0);
      fe(0, '0); check("div_fe2_tick", fe_tick, 1'b1);
      fe(2, '0); check("div_fe3_tick", fe_tick, 1'b0);
      fe(0, '0); check("div_fe4_tick", fe_tick, 1'b1);
      check("div_ticks", tick_cnt - t0, 2);
      check("div_wide",  wide_cnt, 0);
      check("div_fcnt",  frame_count, 16'd4);

      pulse_req(1'b1, 1'b0);
      check("pause_state", run_state, 2'b01);
      t0 = tick_cnt;
      repeat (3) fe(0, '0);
      check("pause_ticks", tick_cnt - t0, 0);
      check("pause_fcnt",  frame_count, 16'd7);
      pulse_req(1'b0, 1'b1);
      check("step_state", run_state, 2'b10);
      fe(0, '0);
      check("step_tick",  fe_tick, 1'b1);
      check("step_back",  run_state, 2'b01);
      check("step_ticks", tick_cnt - t0, 1);
      pulse_req(1'b1, 1'b0);
      pulse_req(1'b1, 1'b0);
      check("pause_again", run_state, 2'b01);
      pulse_req(1'b0, 1'b1);
      pulse_req(1'b1, 1'b0);
      check("step_to_run", run_state, 2'b00);
      pulse_req(1'b1, 1'b0);

      pulse_req(1'b1, 1'b1);
      check("both_state", run_state, 2'b00);
      t0 = tick_cnt;
      fe(0, '0); check("both_fe1_tick", fe_tick, 1'b0);
      fe(0, '0); check("both_fe2_tick", fe_tick, 1'b1);
      check("both_ticks", tick_cnt - t0, 1);
      pulse_req(1'b0, 1'b1);
      check("run_ign_step", run_state, 2'b00);

      idle(3);
      hit = 4'b1001; cycle();
      hit = 4'b0001; idle(2);
      hit = 4'b0000; idle(2);
      fe(0, '0);
      check("coll_val",      fe_collide, 4'b1001);
      check("coll_irq",      fe_irq, 1'b1);
      check("coll_irq_once", irq_after, 1'b0);
      fe(0, '0);
      check("clean_coll", fe_collide, 4'b0000);
      check("clean_irq",  fe_irq, 1'b0);
      fe(0, 4'b0011);
      check("endcyc_coll", fe_collide, 4'b0011);
      check("endcyc_irq",  fe_irq, 1'b1);
      fe(0, '0);
      check("endcyc_next", fe_collide, 4'b0000);

      pulse_req(1'b1, 1'b0);
      pulse_req(1'b0, 1'b1);
      check("rst_pre_step", run_state, 2'b10);
      hit = 4'b0110; cycle();
      #2 reset = 1'b1;
      hit = '0;
      #1;
      check("arst_rgb",   {red, green, blue}, 12'h000);
      check("arst_owner", owner, 3'd4);
      check("arst_state", run_state, 2'b00);
      check("arst_fcnt",  frame_count, 16'd0);
      check("arst_coll",  collide, 4'h0);
      check("arst_tick",  move_tick, 1'b0);
      check("arst_irq",   collide_irq, 1'b0);
      cycle();
      reset = 1'b0;
      cycle();
      fe(0, '0);
      check("arst_acc_clr", fe_collide, 4'h0);
      check("arst_acc_irq", fe_irq, 1'b0);
      check("arst_fcnt1",   frame_count, 16'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
